// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the reciprocal frequency meter:
//   state_e         measurement FSM encoding (ARM, COUNT, DIVIDE, DONE)
//   DIV_W           dividend / quotient width of the serial divider (64)
//   FREQ_W          width of the reported frequency and of the divisor (32)
//   CNT_W           width of the CLK-cycle counter (32)
//   EDGE_W          width of the input-period counter (8, PERIODS <= 255)
//   calc_numerator  N = PERIODS * CLK_HZ * 1000 (mHz scaling), 64 bits
// -----------------------------------------------------------------------------
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_COUNT  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DIV_W  = 64;
    localparam int FREQ_W = 32;
    localparam int CNT_W  = 32;
    localparam int EDGE_W = 8;

    // Cycles-per-period counts are divided into this constant, so the
    // quotient comes out directly in millihertz.
    function automatic logic [DIV_W-1:0] calc_numerator(input logic [63:0] clk_hz,
                                                        input logic [63:0] periods);
        return periods * clk_hz * 64'd1000;
    endfunction

endpackage

// File: rtl/freq_meter_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
// 64/32 restoring divider, one quotient bit per clock, fixed 64-cycle latency.
//   CLK       in   system clock
//   RESET     in   synchronous active-high reset (aborts a division)
//   start     in   one-cycle pulse; dividend/divisor sampled this cycle
//   dividend  in   64-bit unsigned dividend
//   divisor   in   32-bit unsigned divisor
//   busy      out  high from the cycle after start through the done cycle
//   done      out  one-cycle pulse 64 cycles after start; quotient valid
//   quotient  out  64-bit unsigned quotient (all ones when divisor is 0)
// The first quotient bit is produced on the same clock that loads the
// operands, so the last of the 64 steps lands one cycle before done.
// -----------------------------------------------------------------------------
module serial_divider
    import freq_meter_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [DIV_W-1:0]  dividend,
    input  logic [FREQ_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DIV_W-1:0]  quotient
);

    localparam int STEP_W = $clog2(DIV_W);

    logic [FREQ_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0]  quo_q, quo_d;
    logic [FREQ_W-1:0] dsr_q, dsr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [FREQ_W-1:0] rem_in;
    logic [DIV_W-1:0]  quo_in;
    logic [FREQ_W-1:0] dsr_in;
    logic [FREQ_W:0]   trial;
    logic [FREQ_W-1:0] rem_step;
    logic [DIV_W-1:0]  quo_step;

    // One restoring step. The partial remainder is always below the divisor,
    // so a successful subtraction fits back into FREQ_W bits. A zero divisor
    // makes every trial succeed, which yields an all-ones quotient.
    always_comb begin
        rem_in = start ? '0       : rem_q;
        quo_in = start ? dividend : quo_q;
        dsr_in = start ? divisor  : dsr_q;
        trial  = {rem_in, quo_in[DIV_W-1]};
        if (trial >= {1'b0, dsr_in}) begin
            rem_step = trial[FREQ_W-1:0] - dsr_in;
            quo_step = {quo_in[DIV_W-2:0], 1'b1};
        end else begin
            rem_step = trial[FREQ_W-1:0];
            quo_step = {quo_in[DIV_W-2:0], 1'b0};
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        step_d = step_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = rem_step;
            quo_d  = quo_step;
            dsr_d  = divisor;
            step_d = STEP_W'(1);
            busy_d = 1'b1;
        end else if (done_q) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            rem_d  = rem_step;
            quo_d  = quo_step;
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(DIV_W - 1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            step_q <= step_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Reciprocal frequency meter. Counts CLK cycles across PERIODS rising edges of
// SIG_IN and divides PERIODS*CLK_HZ*1000 by that count, reporting mHz.
//   CLK      in   system clock
//   RESET    in   synchronous active-high reset
//   SIG_IN   in   asynchronous square-wave input
//   FREQ     out  last measured frequency in mHz (saturates at 32'hFFFF_FFFF)
//   VALID    out  one-cycle pulse when FREQ updates
//   BUSY     out  high while counting or dividing
//   TIMEOUT  out  last update came from a timeout; cleared by a normal update
// Build option: define FREQ_METER_TIMEOUT_EN to add the idle/overflow timeout
// (FREQ=0, TIMEOUT=1 after TIMEOUT_CYCLES without an input edge). Without it
// the meter waits indefinitely and TIMEOUT stays 0.
// -----------------------------------------------------------------------------
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned PERIODS        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SIG_IN,
    output logic [FREQ_W-1:0] FREQ,
    output logic              VALID,
    output logic              BUSY,
    output logic              TIMEOUT
);

    if (PERIODS < 1 || PERIODS > 255) begin : g_bad_periods
        $error("freq_meter: PERIODS must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("freq_meter: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [DIV_W-1:0]  NUMER     = calc_numerator(64'(CLK_HZ), 64'(PERIODS));
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(PERIODS);

    function automatic logic [FREQ_W-1:0] sat_freq(input logic [DIV_W-1:0] q);
        return (|q[DIV_W-1:FREQ_W]) ? '1 : q[FREQ_W-1:0];
    endfunction

    state_e state_q, state_d;

    logic s1_q, s2_q, s3_q;
    logic edge_det;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] ecnt_q, ecnt_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              valid_q, valid_d;
    logic              tmo_q, tmo_d;

    logic              final_edge;
    logic              timeout_hit;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DIV_W-1:0]  div_quot;

    // Synchronizer plus edge register. Resetting all three to 1 means a high
    // input at reset release cannot look like a rising edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= SIG_IN;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_det   = s2_q & ~s3_q;
    assign final_edge = edge_det && ((ecnt_q + EDGE_W'(1)) == LAST_EDGE);

`ifdef FREQ_METER_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;

    // An input edge takes precedence over reaching the idle limit in the
    // same cycle. A wrapping cycle counter is reported the same way.
    assign timeout_hit = ((state_q == ST_ARM) || (state_q == ST_COUNT)) &&
                         ((!edge_det && (idle_q == 32'(TIMEOUT_CYCLES - 1))) ||
                          ((state_q == ST_COUNT) && (cnt_q == '1)));

    always_comb begin
        idle_d = idle_q;
        if (edge_det || timeout_hit) begin
            idle_d = '0;
        end else if ((state_q == ST_ARM) || (state_q == ST_COUNT)) begin
            idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM: begin
                if (edge_det && !timeout_hit) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (timeout_hit) begin
                    state_d = ST_ARM;
                end else if (final_edge) begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_ARM;
            default:  state_d = ST_ARM;
        endcase
    end

    // FSM: outputs. The divider stays busy through its done cycle, so it
    // covers exactly the DIVIDE state.
    always_comb begin
        BUSY      = (state_q == ST_COUNT) || div_busy;
        div_start = (state_q == ST_COUNT) && final_edge && !timeout_hit;
    end

    // Counters and result registers. The divisor handed to the divider is
    // CNT+1: the cycle count from the arming edge to the final edge.
    always_comb begin
        cnt_d   = cnt_q;
        ecnt_d  = ecnt_q;
        freq_d  = freq_q;
        valid_d = 1'b0;
        tmo_d   = tmo_q;
        if (timeout_hit) begin
            cnt_d   = '0;
            ecnt_d  = '0;
            freq_d  = '0;
            valid_d = 1'b1;
            tmo_d   = 1'b1;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (edge_det) begin
                        cnt_d  = '0;
                        ecnt_d = '0;
                    end
                end
                ST_COUNT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (edge_det) begin
                        ecnt_d = ecnt_q + EDGE_W'(1);
                    end
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        freq_d  = sat_freq(div_quot);
                        valid_d = 1'b1;
                        tmo_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= '0;
            ecnt_q  <= '0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ecnt_q  <= ecnt_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    serial_divider u_div (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (div_start),
        .dividend (NUMER),
        .divisor  (cnt_q + CNT_W'(1)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign FREQ    = freq_q;
    assign VALID   = valid_q;
    assign TIMEOUT = tmo_q;

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

    localparam int unsigned CLK_HZ  = 100_000_000;
    localparam int unsigned PERIODS = 16;
`ifdef FREQ_METER_TIMEOUT_EN
    localparam int unsigned TO_CYC  = 1000;
`else
    localparam int unsigned TO_CYC  = 100_000_000;
`endif
    localparam longint unsigned NUMER = 64'(PERIODS) * 64'(CLK_HZ) * 64'd1000;

    logic        CLK    = 1'b0;
    logic        RESET  = 1'b1;
    logic        SIG_IN = 1'b0;
    logic [31:0] FREQ;
    logic        VALID;
    logic        BUSY;
    logic        TIMEOUT;

    freq_meter #(
        .CLK_HZ         (CLK_HZ),
        .PERIODS        (PERIODS),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .SIG_IN  (SIG_IN),
        .FREQ    (FREQ),
        .VALID   (VALID),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] freq;
        logic        tmo;
    } evt_t;

    evt_t log_q[$];
    evt_t exp_q[$];
    int   rise_q[$];

    always @(negedge CLK) begin
        if (VALID === 1'b1) begin
            evt_t ev;
            ev.cyc  = cyc;
            ev.freq = FREQ;
            ev.tmo  = TIMEOUT;
            log_q.push_back(ev);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(output int rel);
        RESET = 1'b1;
        tick(3);
        RESET = 1'b0;
        rel = cyc;
        log_q.delete();
        rise_q.delete();
    endtask

    // Each period: high for h cycles, low for l cycles; record when each
    // rising level was driven.
    task automatic drive_periods(input int n, input int hi, input int lo, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int h;
            int l;
            h = hi;
            l = lo;
            if (rnd) begin
                h = $urandom_range(120, 2);
                l = $urandom_range(120, 2);
            end
            SIG_IN = 1'b1;
            rise_q.push_back(cyc);
            tick(h);
            SIG_IN = 1'b0;
            tick(l);
        end
    endtask

    function automatic logic [31:0] ref_freq(input longint unsigned d);
        longint unsigned q;
        q = NUMER / d;
        return (q > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

    // Reference: a level driven after posedge c becomes a synchronized edge
    // in cycle c+2. An edge arms only once the meter is idle; the PERIODS-th
    // later edge closes the window, the result shows 65 cycles later and
    // the meter is idle again one cycle after that.
    task automatic build_expect(input int ready);
        bit armed;
        int a;
        int k;
        armed = 1'b0;
        a = 0;
        k = 0;
        exp_q.delete();
        foreach (rise_q[i]) begin
            int e;
            e = rise_q[i] + 2;
            if (!armed) begin
                if (e >= ready) begin
                    armed = 1'b1;
                    a = e;
                    k = 0;
                end
            end else begin
                k++;
                if (k == int'(PERIODS)) begin
                    evt_t x;
                    x.cyc  = e + 65;
                    x.freq = ref_freq(64'(e - a));
                    x.tmo  = 1'b0;
                    exp_q.push_back(x);
                    ready = e + 66;
                    armed = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, " count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s cycle[%0d]", tag, i), 64'(log_q[i].cyc), 64'(exp_q[i].cyc));
            check($sformatf("%s freq[%0d]", tag, i), 64'(log_q[i].freq), 64'(exp_q[i].freq));
            check($sformatf("%s timeout[%0d]", tag, i), 64'(log_q[i].tmo), 64'(exp_q[i].tmo));
        end
    endtask

    task automatic measure(input string tag, input int n, input int hi, input int lo,
                           input bit rnd, input int ready);
        drive_periods(n, hi, lo, rnd);
        tick(80);
        build_expect(ready);
        compare_log(tag);
    endtask

    function automatic logic [31:0] first_freq();
        return (log_q.size() > 0) ? log_q[0].freq : 'x;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r;
        bit  busy_seen;

        // Reset state
        SIG_IN = 1'b0;
        do_reset(r);
        check("reset FREQ", 64'(FREQ), 64'd0);
        check("reset VALID", 64'(VALID), 64'd0);
        check("reset BUSY", 64'(BUSY), 64'd0);
        check("reset TIMEOUT", 64'(TIMEOUT), 64'd0);
        tick(2);

        // 100-cycle period
        measure("p100", 17, 50, 50, 1'b0, r);
        check("p100 value", 64'(first_freq()), 64'd1_000_000_000);

        // 333-cycle period, floor of a non-integer quotient
        do_reset(r);
        tick(2);
        measure("p333", 17, 166, 167, 1'b0, r);
        check("p333 value", 64'(first_freq()), 64'd300_300_300);

        // 20-cycle period saturates
        do_reset(r);
        tick(2);
        measure("p20", 17, 10, 10, 1'b0, r);
        check("p20 value", 64'(first_freq()), 64'h0000_0000_FFFF_FFFF);

        // Randomized high/low times, several back-to-back measurements
        for (int n = 0; n < 3; n++) begin
            do_reset(r);
            tick($urandom_range(5, 1));
            measure($sformatf("rnd%0d", n), 40, 0, 0, 1'b1, r);
        end

        // Reset during DIVIDE aborts without a VALID pulse
        do_reset(r);
        tick(2);
        drive_periods(16, 50, 50, 1'b0);
        SIG_IN = 1'b1;
        tick(30);
        check("middiv BUSY before reset", 64'(BUSY), 64'd1);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        r = cyc;
        check("middiv BUSY after reset", 64'(BUSY), 64'd0);
        check("middiv FREQ after reset", 64'(FREQ), 64'd0);
        check("middiv VALID after reset", 64'(VALID), 64'd0);
        tick(20);
        SIG_IN = 1'b0;
        tick(50);
        check("middiv no VALID", 64'(log_q.size()), 64'd0);
        rise_q.delete();
        log_q.delete();
        measure("post-reset", 17, 50, 50, 1'b0, r);
        check("post-reset value", 64'(first_freq()), 64'd1_000_000_000);

        // SIG_IN high at reset release produces no edge
        SIG_IN = 1'b1;
        do_reset(r);
        busy_seen = 1'b0;
        repeat (50) begin
            tick(1);
            busy_seen = busy_seen | BUSY;
        end
        check("high-release BUSY", 64'(busy_seen), 64'd0);
        SIG_IN = 1'b0;
        tick(5);
        measure("high-release", 17, 50, 50, 1'b0, r);
        check("high-release value", 64'(first_freq()), 64'd1_000_000_000);

`ifdef FREQ_METER_TIMEOUT_EN
        // Idle input times out, then a normal measurement clears TIMEOUT
        SIG_IN = 1'b0;
        do_reset(r);
        tick(999);
        check("tmo VALID early", 64'(VALID), 64'd0);
        tick(1);
        check("tmo VALID", 64'(VALID), 64'd1);
        check("tmo FREQ", 64'(FREQ), 64'd0);
        check("tmo TIMEOUT", 64'(TIMEOUT), 64'd1);
        r = cyc;
        log_q.delete();
        rise_q.delete();
        measure("after-tmo", 17, 50, 50, 1'b0, r);
        check("after-tmo value", 64'(first_freq()), 64'd1_000_000_000);
        check("after-tmo TIMEOUT", 64'(TIMEOUT), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
